// File: rtl/fp_result_normalize.sv
// Post-add normalizer: magnitude/sign recovery, then one normalizing shift per cycle.
// FP_NORM_ROUND_EN adds round-half-up on the right-shift path. Without it, that path truncates.
module fp_result_normalize #(
  parameter int MANT_W = 6,
  parameter int EXP_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [MANT_W+1:0] in_sum,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_zero,
  output logic              out_ovf,
  output logic              out_unf
);
  typedef enum logic [1:0] {IDLE, CONV, NORM, DONE} state_t;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  state_t            state;
  logic [MANT_W+1:0] sum_r;
  logic [MANT_W:0]   mag;
  logic [EXP_W-1:0]  exp_r;
  logic              sign_r;
  logic [MANT_W+1:0] neg_sum;
  logic [MANT_W:0]   abs_sum;

  assign in_ready = (state == IDLE) && !rst;
  assign neg_sum  = -sum_r;
  assign abs_sum  = sum_r[MANT_W+1] ? neg_sum[MANT_W:0] : sum_r[MANT_W:0];

`ifdef FP_NORM_ROUND_EN
  logic [MANT_W:0] rnd_sum;
  assign rnd_sum = {1'b0, mag[MANT_W:1]} + {{MANT_W{1'b0}}, mag[0]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sum_r     <= '0;
      mag       <= '0;
      exp_r     <= '0;
      sign_r    <= 1'b0;
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_mant  <= '0;
      out_exp   <= '0;
      out_zero  <= 1'b0;
      out_ovf   <= 1'b0;
      out_unf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sum_r  <= in_sum;
          sign_r <= in_sign;
          exp_r  <= in_exp;
          state  <= CONV;
        end
        CONV: begin
          mag    <= abs_sum;
          sign_r <= sign_r ^ sum_r[MANT_W+1];
          state  <= NORM;
        end
        NORM: begin
          // Every case terminates except the left shift, which overrides these two.
          state     <= DONE;
          out_valid <= 1'b1;
          if (mag == '0) begin
            out_zero <= 1'b1;
          end else if (mag[MANT_W] && exp_r == EXP_MAX) begin
            out_sign <= sign_r;
            out_mant <= '1;
            out_exp  <= EXP_MAX;
            out_ovf  <= 1'b1;
          end else if (mag[MANT_W]) begin
            out_sign <= sign_r;
`ifdef FP_NORM_ROUND_EN
            if (rnd_sum[MANT_W]) begin
              if (exp_r == EXP_MAX - EXP_W'(1)) begin
                out_mant <= '1;
                out_exp  <= EXP_MAX;
                out_ovf  <= 1'b1;
              end else begin
                out_mant <= {1'b1, {(MANT_W-1){1'b0}}};
                out_exp  <= exp_r + EXP_W'(2);
              end
            end else begin
              out_mant <= rnd_sum[MANT_W-1:0];
              out_exp  <= exp_r + EXP_W'(1);
            end
`else
            out_mant <= mag[MANT_W:1];
            out_exp  <= exp_r + EXP_W'(1);
`endif
          end else if (mag[MANT_W-1]) begin
            out_sign <= sign_r;
            out_mant <= mag[MANT_W-1:0];
            out_exp  <= exp_r;
          end else if (exp_r == '0) begin
            out_sign <= sign_r;
            out_mant <= mag[MANT_W-1:0];
            out_unf  <= 1'b1;
          end else begin
            mag       <= mag << 1;
            exp_r     <= exp_r - EXP_W'(1);
            state     <= NORM;
            out_valid <= 1'b0;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_sign  <= 1'b0;
          out_mant  <= '0;
          out_exp   <= '0;
          out_zero  <= 1'b0;
          out_ovf   <= 1'b0;
          out_unf   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_result_normalize.sv
// Randomized and directed checks of fp_result_normalize against an integer-arithmetic model.
module tb_fp_result_normalize;
  localparam int MANT_W = 6;
  localparam int EXP_W  = 4;
  localparam int EMAX   = (1 << EXP_W) - 1;
  localparam int MMAX   = (1 << MANT_W) - 1;

  typedef struct packed {
    logic              sign;
    logic [MANT_W-1:0] mant;
    logic [EXP_W-1:0]  exp;
    logic              zero;
    logic              ovf;
    logic              unf;
  } res_t;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_sign = 1'b0, out_ready = 1'b0;
  logic [MANT_W+1:0] in_sum = '0;
  logic [EXP_W-1:0]  in_exp = '0;
  logic in_ready, out_valid, out_sign, out_zero, out_ovf, out_unf;
  logic [MANT_W-1:0] out_mant;
  logic [EXP_W-1:0]  out_exp;

  int checks = 0, failures = 0;

  fp_result_normalize #(.MANT_W(MANT_W), .EXP_W(EXP_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_sum(in_sum), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_mant(out_mant), .out_exp(out_exp), .out_zero(out_zero),
    .out_ovf(out_ovf), .out_unf(out_unf)
  );

  always #5 clk = ~clk;

  function automatic res_t observed();
    return '{out_sign, out_mant, out_exp, out_zero, out_ovf, out_unf};
  endfunction

  // Reference: treat the sum as a signed integer and normalize with arithmetic;
  // lat is the edge on which out_valid is seen, counting the acceptance edge as 1.
  function automatic res_t model(input int sum, input int e, input bit s, output int lat);
    res_t r = '0;
    int mag = (sum < 0) ? -sum : sum;
    bit sg = s ^ (sum < 0);
    int k = 0;
    int m;
    while (1) begin
      if (mag == 0) begin
        r.zero = 1; break;
      end else if (mag >= (1 << MANT_W)) begin
        r.sign = sg;
        m = mag / 2;
`ifdef FP_NORM_ROUND_EN
        m = m + (mag % 2);
`endif
        if (e == EMAX) begin
          r.mant = MMAX; r.exp = EMAX; r.ovf = 1;
        end else if (m == (1 << MANT_W)) begin
          if (e + 2 > EMAX) begin
            r.mant = MMAX; r.exp = EMAX; r.ovf = 1;
          end else begin
            r.mant = 1 << (MANT_W - 1); r.exp = e + 2;
          end
        end else begin
          r.mant = m; r.exp = e + 1;
        end
        break;
      end else if (mag >= (1 << (MANT_W - 1))) begin
        r.sign = sg; r.mant = mag; r.exp = e; break;
      end else if (e == 0) begin
        r.sign = sg; r.mant = mag; r.unf = 1; break;
      end else begin
        mag = mag * 2; e = e - 1; k++;
      end
    end
    lat = 3 + k;
    return r;
  endfunction

  // Offers one op and waits for out_valid, leaving the DUT in DONE; lat = -1 on timeout.
  task automatic run_op(input int sum, input int e, input bit s, output int lat, output res_t r);
    int n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    in_valid = 1; in_sum = (MANT_W+2)'(sum); in_exp = EXP_W'(e); in_sign = s;
    @(posedge clk); #1;
    in_valid = 0; in_sum = '0; in_exp = '0; in_sign = 0;
    lat = -1;
    for (int i = 2; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
    end
    r = observed();
  endtask

  task automatic release_op();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic check_op(input string name, input int sum, input int e, input bit s);
    res_t got, exp_r;
    int lat, exp_lat;
    exp_r = model(sum, e, s, exp_lat);
    run_op(sum, e, s, lat, got);
    checks++;
    if (got !== exp_r) begin
      failures++;
      $display("FAIL %s result sum=%0d exp=%0d sign=%0d: got %h want %h", name, sum, e, s, got, exp_r);
    end
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s latency sum=%0d exp=%0d: got %0d want %0d", name, sum, e, lat, exp_lat);
    end
    release_op();
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, observed()} !== '0) begin
      failures++;
      $display("FAIL reset_state: got rdy=%b vld=%b res=%h want all zero", in_ready, out_valid, observed());
    end
    rst = 0; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    res_t want, got;
    int lat;
    check_op("pos45", 45, 5, 0);
    want = '{1'b0, 6'b101101, 4'd5, 1'b0, 1'b0, 1'b0};
    run_op(45, 5, 0, lat, got);
    checks++;
    if (got !== want || lat !== 3) begin
      failures++;
      $display("FAIL literal_pos45: got %h lat %0d want %h lat 3", got, lat, want);
    end
    release_op();
    want = '{1'b1, 6'b110000, 4'd2, 1'b0, 1'b0, 1'b0};
    run_op(-3, 6, 0, lat, got);
    checks++;
    if (got !== want || lat !== 7) begin
      failures++;
      $display("FAIL literal_neg3: got %h lat %0d want %h lat 7", got, lat, want);
    end
    release_op();
`ifdef FP_NORM_ROUND_EN
    want = '{1'b0, 6'b100000, 4'd5, 1'b0, 1'b0, 1'b0};
`else
    want = '{1'b0, 6'b111111, 4'd4, 1'b0, 1'b0, 1'b0};
`endif
    run_op(127, 3, 0, lat, got);
    checks++;
    if (got !== want || lat !== 3) begin
      failures++;
      $display("FAIL literal_127: got %h lat %0d want %h", got, lat, want);
    end
    release_op();
    want = '{1'b0, 6'b111111, 4'd15, 1'b0, 1'b1, 1'b0};
    run_op(64, 15, 0, lat, got);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL literal_ovf: got %h want %h", got, want);
    end
    release_op();
    want = '{1'b0, 6'b000000, 4'd0, 1'b1, 1'b0, 1'b0};
    run_op(0, 9, 1, lat, got);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL literal_zero: got %h want %h", got, want);
    end
    release_op();
    want = '{1'b0, 6'b000100, 4'd0, 1'b0, 1'b0, 1'b1};
    run_op(1, 2, 0, lat, got);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL literal_unf: got %h want %h", got, want);
    end
    release_op();
    check_op("round_carry_e14", 127, 14, 1);
    check_op("odd_e0", 65, 0, 0);
  endtask

  task automatic test_backpressure();
    res_t first, got, want;
    int lat, exp_lat;
    want = model(-37, 8, 1, exp_lat);
    run_op(-37, 8, 1, lat, first);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      got = observed();
      checks++;
      if (got !== want || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL backpressure cyc%0d: got %h vld=%b rdy=%b want %h vld=1 rdy=0", i, got, out_valid, in_ready, want);
      end
    end
    release_op();
    checks++;
    if (out_valid !== 1'b0 || observed() !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_handshake: got vld=%b res=%h rdy=%b want 0/0/1", out_valid, observed(), in_ready);
    end
  endtask

  task automatic test_reset_midflight();
    in_valid = 1; in_sum = 8'd1; in_exp = 4'd12; in_sign = 0;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || observed() !== '0) begin
      failures++;
      $display("FAIL reset_in_norm: got vld=%b rdy=%b res=%h want 0/0/0", out_valid, in_ready, observed());
    end
    rst = 0; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_norm_ready: got %b want 1", in_ready);
    end
    check_op("after_reset", -50, 7, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int sum = int'($urandom_range(254, 0)) - 127;
      check_op("random", sum, int'($urandom_range(EMAX, 0)), 1'($urandom_range(1, 0)));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      check_op("b2b", (i * 23) - 60, (i * 3) % (EMAX + 1), i[0]);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midflight();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fp_result_normalize.md
FP_RESULT_NORMALIZE -- requirements
Module: fp_result_normalize

Interface
REQ-001 SHALL have parameter MANT_W, default 6: stored mantissa width, with the MSB as the explicit leading one.
REQ-002 SHALL have parameter EXP_W, default 4: unsigned exponent width.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: an input operation is offered.
REQ-006 SHALL have port in_ready, output, 1: the block accepts the offered operation.
REQ-007 SHALL have port in_sign, input, 1: sign of the larger (unshifted) operand.
REQ-008 SHALL have port in_sum, input, MANT_W+2: two's-complement adder result.
REQ-009 SHALL have port in_exp, input, EXP_W: exponent of the larger operand.
REQ-010 SHALL have port out_valid, output, 1: a result is presented.
REQ-011 SHALL have port out_ready, input, 1: the consumer takes the result.
REQ-012 SHALL have port out_sign, output, 1: result sign.
REQ-013 SHALL have port out_mant, output, MANT_W: normalized magnitude.
REQ-014 SHALL have port out_exp, output, EXP_W: result exponent.
REQ-015 SHALL have port out_zero, output, 1: zero flag.
REQ-016 SHALL have port out_ovf, output, 1: overflow flag.
REQ-017 SHALL have port out_unf, output, 1: underflow flag.

Function
REQ-018 SHALL implement states IDLE, CONV, NORM, DONE; in_ready = (state==IDLE) && !rst.
REQ-019 SHALL, on an edge with in_valid && in_ready, register in_sum, in_sign and in_exp, then go IDLE->CONV.
REQ-020 SHALL, in CONV (one cycle), set mag = |in_sum| (MANT_W+1 bits) and sign = in_sign ^ in_sum[MSB], then go CONV->NORM.
REQ-021 SHALL, on each NORM edge, take the first matching case in this order:
- (a) mag==0: mant=0, exp=0, sign=0, zero=1 -> DONE.
- (b) mag[MANT_W]==1 and exp==all-ones: mant=all-ones, exp=all-ones, ovf=1 -> DONE.
- (c) mag[MANT_W]==1: mant=mag>>1, exp+1 -> DONE.
- (d) mag[MANT_W-1]==1: mant=mag[MANT_W-1:0] -> DONE.
- (e) exp==0: mant=mag[MANT_W-1:0], unf=1 -> DONE.
- (f) otherwise: mag<<=1, exp-1, stay in NORM.
REQ-022 SHALL hold out_valid=1 in DONE with all outputs stable until out_ready; DONE->IDLE on the out_valid && out_ready edge.
REQ-023 SHALL NOT accept a new input until the cycle after the DONE handshake completes (no overlap).
REQ-024 SHALL meet this latency, counted from the acceptance edge: out_valid high after edge 3+k, where k = number of left shifts (0..MANT_W-1).
REQ-025 SHALL keep flags mutually exclusive, and keep outputs 0 whenever out_valid=0.

Reset
REQ-026 SHALL, on an rst edge in any state, go to IDLE and clear out_valid, out_sign, out_mant, out_exp, out_zero, out_ovf and out_unf to 0.
REQ-027 SHALL discard any in-flight operation on reset.
REQ-028 SHALL hold in_ready=0 while rst=1, and in_ready=1 on the first cycle after release.

Configuration
REQ-029 SHALL apply round-half-up in case (c) when FP_NORM_ROUND_EN is defined: mant=(mag>>1)+mag[0].
REQ-030 SHALL, under FP_NORM_ROUND_EN, handle a rounding carry-out by setting mant=1000..0 and exp+2, raising ovf with saturation if exp would exceed all-ones.
REQ-031 SHALL truncate in case (c) when FP_NORM_ROUND_EN is undefined.
REQ-032 SHALL keep latency identical in both builds.

Verification (MANT_W=6, EXP_W=4)
REQ-033 SHALL cover: in_sum=+45, in_exp=5, in_sign=0 -> mant=101101, exp=5, sign=0, out_valid after edge 3.
REQ-034 SHALL cover: in_sum=-3 (8'hFD), in_exp=6, in_sign=0 -> sign=1, mant=110000, exp=2, out_valid after edge 7.
REQ-035 SHALL cover: in_sum=+127, in_exp=3 -> truncating build mant=111111, exp=4; FP_NORM_ROUND_EN build mant=100000, exp=5; in_sum=+64, in_exp=15 -> ovf=1, mant=111111, exp=15.
REQ-036 SHALL cover: in_sum=0 -> zero=1, mant=0, exp=0, sign=0; in_sum=+1, in_exp=2 -> mant=000100, exp=0, unf=1.
REQ-037 SHALL cover: out_ready low 4 cycles in DONE -> outputs stable, in_ready=0; rst pulsed in NORM -> out_valid=0 next cycle, in_ready=1 after release, next op correct.
